// File: rtl/semaforo.sv
`default_nettype none
// ============================================================================
//  Module   : semaforo
//  Purpose  : Two-road traffic-light controller. A Moore FSM runs
//             green -> yellow -> all-red clearance on each road in turn.
//             A green phase yields only when the other road has demand, the
//             minimum green time has elapsed, and either its own road is
//             empty or the maximum green time has been reached.
//  Ports    : clk   - single clock, rising-edge
//             rst_n - synchronous active-low reset (forces A green, cnt 0)
//             A, B  - vehicle-demand sensors, sampled every cycle
//             Sa,Ya - green / yellow lamps road A (red = both low)
//             Sb,Yb - green / yellow lamps road B (red = both low)
//  Revision : 1.0 - initial release
// ============================================================================
module semaforo #(
  parameter int GREEN_MIN    = 4,
  parameter int GREEN_MAX    = 12,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  output logic Sa,
  output logic Sb,
  output logic Ya,
  output logic Yb
);

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    RED_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    RED_BA   = 3'd5
  } state_t;

  // Terminal counts: cnt starts at 0 on entry, so a phase of N cycles ends
  // when cnt reaches N-1.
  localparam logic [7:0] C_GMIN_LAST   = 8'(GREEN_MIN - 1);
  localparam logic [7:0] C_GMAX_LAST   = 8'(GREEN_MAX - 1);
  localparam logic [7:0] C_YELLOW_LAST = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] C_RED_LAST    = 8'(ALL_RED_TIME - 1);
  localparam logic [7:0] C_CNT_SAT     = 8'd255;

  state_t     r_state;
  logic [7:0] r_cnt;

  state_t     w_next;
  logic       w_a_yield;
  logic       w_b_yield;

  // Green yields only to live demand on the other road; the max-green cap
  // matters only while the own road still has traffic.
  assign w_a_yield = (r_cnt >= C_GMIN_LAST) && B && (!A || (r_cnt >= C_GMAX_LAST));
  assign w_b_yield = (r_cnt >= C_GMIN_LAST) && A && (!B || (r_cnt >= C_GMAX_LAST));

  always_comb begin
    w_next = r_state;
    case (r_state)
      A_GREEN:  if (w_a_yield)              w_next = A_YELLOW;
      A_YELLOW: if (r_cnt == C_YELLOW_LAST) w_next = RED_AB;
      RED_AB:   if (r_cnt == C_RED_LAST)    w_next = B_GREEN;
      B_GREEN:  if (w_b_yield)              w_next = B_YELLOW;
      B_YELLOW: if (r_cnt == C_YELLOW_LAST) w_next = RED_BA;
      RED_BA:   if (r_cnt == C_RED_LAST)    w_next = A_GREEN;
      default:                              w_next = A_GREEN;
    endcase
  end

  // Lamps are registered from the next state so they change on the same
  // edge as the state register and never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= A_GREEN;
      r_cnt   <= 8'd0;
      Sa      <= 1'b1;
      Ya      <= 1'b0;
      Sb      <= 1'b0;
      Yb      <= 1'b0;
    end else begin
      r_state <= w_next;
      // An illegal encoding always maps to A_GREEN, which differs from the
      // current value, so the counter is cleared on that recovery too.
      if (w_next != r_state) begin
        r_cnt <= 8'd0;
      end else if (r_cnt != C_CNT_SAT) begin
        r_cnt <= r_cnt + 8'd1;
      end
      Sa <= (w_next == A_GREEN);
      Ya <= (w_next == A_YELLOW);
      Sb <= (w_next == B_GREEN);
      Yb <= (w_next == B_YELLOW);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_semaforo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_semaforo
//  Purpose  : Self-checking bench for semaforo (default parameters).
//             Stimulus pushes the lamp pattern expected after each clock
//             edge into a queue; an independent monitor pops and compares
//             on the falling edge. Lamp vector order is {Sa, Ya, Sb, Yb}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_semaforo;

  localparam logic [3:0] C_GA  = 4'b1000;
  localparam logic [3:0] C_YA  = 4'b0100;
  localparam logic [3:0] C_GB  = 4'b0010;
  localparam logic [3:0] C_YB  = 4'b0001;
  localparam logic [3:0] C_RED = 4'b0000;

  typedef struct {
    logic [3:0] lamps;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic A = 1'b0;
  logic B = 1'b0;
  logic Sa, Sb, Ya, Yb;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;

  semaforo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Sa    (Sa),
    .Sb    (Sb),
    .Ya    (Ya),
    .Yb    (Yb)
  );

  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then record what the lamps must show
  // after the following rising edge. Repeated n times.
  task automatic step(input int n, input logic r, input logic a, input logic b,
                      input logic [3:0] lamps, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = r;
      A     = a;
      B     = b;
      @(posedge clk);
      e.lamps = lamps;
      e.tag   = tag;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares every cycle the scoreboard holds an expectation.
  initial begin
    exp_t       e;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {Sa, Ya, Sb, Yb};
        n_cmp++;
        if (act !== e.lamps) begin
          n_fail++;
          $display("FAIL %s: lamps {Sa,Ya,Sb,Yb} got %b expected %b at %0t",
                   e.tag, act, e.lamps, $time);
        end
        n_cmp++;
        if ($countones(act) > 1) begin
          n_fail++;
          $display("FAIL onehot_%s: lamps got %b expected at most one high at %0t",
                   e.tag, act, $time);
        end
      end
    end
  end

  initial begin
    // Reset for 2 cycles; sensors active but must be ignored.
    step(2, 1'b0, 1'b1, 1'b1, C_GA, "reset");

    // No demand: A stays green.
    step(20, 1'b1, 1'b0, 1'b0, C_GA, "idle_hold");

    // B demand only: 4 green (reset cycle + 3), 2 yellow, 1 red, B green held.
    step(1, 1'b0, 1'b0, 1'b1, C_GA,  "b_only_rst");
    step(3, 1'b1, 1'b0, 1'b1, C_GA,  "b_only_ga");
    step(2, 1'b1, 1'b0, 1'b1, C_YA,  "b_only_ya");
    step(1, 1'b1, 1'b0, 1'b1, C_RED, "b_only_red");
    step(6, 1'b1, 1'b0, 1'b1, C_GB,  "b_only_gb");

    // Both roads busy: max green on each side, period 30, two periods.
    step(1,  1'b0, 1'b1, 1'b1, C_GA, "both_rst");
    step(11, 1'b1, 1'b1, 1'b1, C_GA, "both_ga0");
    for (int p = 0; p < 2; p++) begin
      step(2,  1'b1, 1'b1, 1'b1, C_YA,  "both_ya");
      step(1,  1'b1, 1'b1, 1'b1, C_RED, "both_rab");
      step(12, 1'b1, 1'b1, 1'b1, C_GB,  "both_gb");
      step(2,  1'b1, 1'b1, 1'b1, C_YB,  "both_yb");
      step(1,  1'b1, 1'b1, 1'b1, C_RED, "both_rba");
      step(12, 1'b1, 1'b1, 1'b1, C_GA,  "both_ga");
    end

    // A-only demand once B green starts: B green lasts exactly min green.
    step(2, 1'b1, 1'b1, 1'b1, C_YA,  "a_only_ya");
    step(1, 1'b1, 1'b1, 1'b0, C_RED, "a_only_rab");
    step(4, 1'b1, 1'b1, 1'b0, C_GB,  "a_only_gb");
    step(2, 1'b1, 1'b1, 1'b0, C_YB,  "a_only_yb");
    step(1, 1'b1, 1'b1, 1'b0, C_RED, "a_only_rba");
    step(4, 1'b1, 1'b1, 1'b0, C_GA,  "a_only_ga");

    // Reset mid-yellow: back to A green, full min green needed again.
    step(1, 1'b1, 1'b0, 1'b1, C_YA,  "midy_ya");
    step(1, 1'b0, 1'b0, 1'b1, C_GA,  "midy_rst");
    step(3, 1'b1, 1'b0, 1'b1, C_GA,  "midy_ga");
    step(2, 1'b1, 1'b0, 1'b1, C_YA,  "midy_ya2");
    step(1, 1'b1, 1'b0, 1'b1, C_RED, "midy_red");
    // Reset mid-clearance: A green instead of B green.
    step(1, 1'b0, 1'b0, 1'b1, C_GA,  "midr_rst");

    // Demand withdrawn before min green: no switch; returns later -> switch.
    step(2, 1'b1, 1'b0, 1'b1, C_GA,  "drop_ga_b");
    step(4, 1'b1, 1'b0, 1'b0, C_GA,  "drop_ga_nob");
    step(2, 1'b1, 1'b0, 1'b1, C_YA,  "drop_ya");
    step(1, 1'b1, 1'b0, 1'b1, C_RED, "drop_red");
    step(1, 1'b1, 1'b0, 1'b1, C_GB,  "drop_gb");

    stim_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    int guard;
    wait (stim_done);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time got %0t expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/semaforo.md
SEMAFORO -- requirements
Module: semaforo

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green duration in clock cycles (legal 1..255).
REQ-002 Parameter GREEN_MAX, default 12: maximum green duration while the other road has demand (legal GREEN_MIN..255).
REQ-003 Parameter YELLOW_TIME, default 2: yellow duration in cycles (legal 1..255).
REQ-004 Parameter ALL_RED_TIME, default 1: all-red clearance duration in cycles (legal 1..255).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 A  input  1  vehicle-demand sensor, road A (1 = vehicle waiting/present).
REQ-008 B  input  1  vehicle-demand sensor, road B.
REQ-009 Sa  output  1  green lamp, road A.
REQ-010 Sb  output  1  green lamp, road B.
REQ-011 Ya  output  1  yellow lamp, road A.
REQ-012 Yb  output  1  yellow lamp, road B; red for a road = its green and yellow both 0.

Function
REQ-013 Moore FSM with six states: A_GREEN, A_YELLOW, RED_AB (clearance A->B), B_GREEN, B_YELLOW, RED_BA (clearance B->A).
REQ-014 Outputs decoded only from state: Sa=1 only in A_GREEN, Ya=1 only in A_YELLOW, Sb=1 only in B_GREEN, Yb=1 only in B_YELLOW; all four 0 in RED_AB/RED_BA.
REQ-015 Invariant: at most one of Sa, Ya, Sb, Yb high in any cycle; never a green/yellow on both roads.
REQ-016 8-bit cycle counter cnt: 0 on state entry; +1 each cycle the state is held; saturates at 255.
REQ-017 A_GREEN -> A_YELLOW when cnt >= GREEN_MIN-1 AND B=1 AND (A=0 OR cnt >= GREEN_MAX-1); otherwise hold.
REQ-018 B_GREEN -> B_YELLOW: mirror of REQ-017 with A/B swapped.
REQ-019 No demand on the other road: green holds indefinitely, cnt saturates, no wrap.
REQ-020 A_YELLOW -> RED_AB when cnt = YELLOW_TIME-1; RED_AB -> B_GREEN when cnt = ALL_RED_TIME-1; B side mirrors (B_YELLOW -> RED_BA -> A_GREEN).
REQ-021 A, B sampled every cycle, no latching: demand dropped before GREEN_MIN expires does not cause a switch.
REQ-022 Yellow and all-red phases run to completion regardless of A/B.
REQ-023 Unused state encodings: next state A_GREEN, cnt 0.

Reset
REQ-024 rst_n=0 at rising edge: state A_GREEN, cnt 0, so Sa=1, Ya=0, Sb=0, Yb=0 from that edge on.
REQ-025 Reset overrides any transition in any state, including mid-yellow/mid-clearance.
REQ-026 A and B are ignored while rst_n=0; timing restarts from cnt 0 on the first edge with rst_n=1.

Verification (defaults; cycle 0 = first edge with rst_n=1)
REQ-027 rst_n=0 for 2 cycles -> Sa=1, Ya=Sb=Yb=0.
REQ-028 A=0,B=0 for 20 cycles after reset -> Sa=1 throughout, no other lamp.
REQ-029 A=0,B=1 from reset -> Sa=1 for 4 cycles, Ya=1 for 2 cycles, all-off 1 cycle, then Sb=1 and held while A=0.
REQ-030 A=1,B=1 continuous -> Sa 12 cycles, Ya 2, all-off 1, Sb 12, Yb 2, all-off 1; repeats with period 30; one-hot check every cycle.
REQ-031 A=1,B=0 after reaching B_GREEN -> Sb held exactly 4 cycles in B_GREEN, then Yb 2, all-off 1, Sa=1.
REQ-032 rst_n pulsed low 1 cycle during A_YELLOW -> Sa=1 after that edge; next switch needs full GREEN_MIN again.
